mux_scan_sampler: RTL
=====================

// Module: mux_scan_sampler
// PURPOSE
//   Upstream sequencer for the enable-high channel-select mux tree (4:1 / 10:1 muxes).
//   On start, walks every unmasked channel and drives sel/en to the mux.
//   Waits SETTLE_CYC cycles per channel, then captures the mux output y_in.
//   Delivers the assembled N_CH-bit snapshot downstream on a valid/ready handshake.
// PARAMETERS
//   N_CH        10   number of mux channels scanned (2..16)
//   SEL_W       4    select width driven to the mux; 2**SEL_W >= N_CH
//   SETTLE_CYC  3    cycles en/sel are held per channel; y_in sampled on last (>=1)
// PORTS
//   clk     in   1      single clock; all logic rising-edge
//   rst_n   in   1      reset, asynchronous assert, active-low
//   start   in   1      scan request; honoured only in IDLE
//   mask    in   N_CH   channel enable mask; latched at the accepted start
//   sel     out  SEL_W  mux select (channel index)
//   en      out  1      mux enable; high only while a channel is being dwelt on
//   y_in    in   1      mux output Y, combinational from sel/en
//   data    out  N_CH   snapshot; bit i = sampled y_in of channel i, 0 if masked
//   valid   out  1      data valid; held until ready
//   ready   in   1      downstream accept
//   busy    out  1      high in SCAN and DONE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, sel=0, en=0, data=0, valid=0, busy=0,
//     counter=0, latched mask=0. Takes effect immediately, including mid-scan or mid-DONE;
//     partial results are discarded.
//   FSM states: IDLE, SCAN, DONE.
//   IDLE: en=0, sel=0. When start=1 at an edge, latch mask and clear the data shadow.
//     If the lowest set mask bit exists, go to SCAN with ch = that bit. Otherwise go to DONE.
//   SCAN: en=1, sel=ch, dwell counter runs 0..SETTLE_CYC-1.
//     At the edge where counter==SETTLE_CYC-1:
//       - shadow[ch] <= y_in; counter <= 0;
//       - ch <= next set mask bit above ch if one exists, else go to DONE.
//     Switching channels never drops en between channels (back-to-back dwell).
//   DONE: en=0, sel=0, data=shadow, valid=1. On valid&&ready, return to IDLE and drop valid.
//     data holds its value until the next accepted start.
//   start is ignored in SCAN and in DONE; there is no queueing.
//     start in the same cycle as the DONE->IDLE handshake is also ignored.
//   Latency: with K enabled channels, start accepted at edge t0, valid is high from the
//     cycle after edge t0+K*SETTLE_CYC. For K=0, valid is high the cycle after t0.
//   Width rules: counter width = clog2(SETTLE_CYC)+1; ch width = SEL_W.
//     Mask bits >= N_CH do not exist, so sel never exceeds N_CH-1.
//   ready high outside DONE has no effect.
// STRUCTURE
//   Shared package mux_pkg:
//     - state encoding localparams ST_IDLE/ST_SCAN/ST_DONE
//     - default N_CH/SEL_W constants reused by the mux tree top
//   Sub-module next_ch_find:
//     - combinational priority search for the lowest set mask bit strictly above ch
//     - outputs {found, idx}; also used with ch=-1 semantics (from_start) for the first channel
//   Everything else (FSM, dwell counter, shadow/data registers) lives in this module.
// TESTING
//   Bench drives y_in from a behavioural 10:1 enable-high mux over pattern I; defaults otherwise.
//   1 Reset: hold rst_n=0 with start=1 -> sel=0, en=0, valid=0, busy=0, data=0 throughout.
//   2 Full scan: mask=10'h3FF, I=10'b10_1100_0101, start pulse ->
//       - sel steps 0..9, 3 cycles each, en=1 for 30 cycles
//       - valid rises after the 30th edge with data=10'h2C5
//   3 Masked scan: mask=10'b00_0010_0101, I=10'h3FF ->
//       - sel visits only 0, 2, 5 (9 cycles)
//       - data=10'h025
//   4 Empty mask: mask=0 and start -> no en pulse; valid on the next cycle with data=0.
//   5 Backpressure / start while busy: ready=0 for 20 cycles after valid; pulse start during SCAN and DONE ->
//       - valid and data stable, no rescan
//       - ready=1 -> IDLE next cycle
//   6 Reset mid-scan: assert rst_n=0 asynchronously while sel=4 ->
//       - en=0, sel=0 immediately (before the next edge)
//       - a fresh start after release performs a clean full scan

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the channel-select mux tree and its scan sequencer.
package mux_pkg;

  localparam int DEF_N_CH       = 10;
  localparam int DEF_SEL_W      = 4;
  localparam int DEF_SETTLE_CYC = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Dwell counter must hold SETTLE_CYC-1; the +1 keeps SETTLE_CYC=1 at one bit.
  function automatic int dwell_cnt_w(input int settle_cyc);
    return $clog2(settle_cyc) + 1;
  endfunction

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Signal bundle between the scan sequencer, the mux tree and the downstream snapshot consumer.
interface mux_scan_sampler_if
  import mux_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W
);

  logic             start;
  logic [N_CH-1:0]  mask;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             y_in;
  logic [N_CH-1:0]  data;
  logic             valid;
  logic             ready;
  logic             busy;

  modport master (
    input  start, mask, y_in, ready,
    output sel, en, data, valid, busy
  );

  modport slave (
    output start, mask, y_in, ready,
    input  sel, en, data, valid, busy
  );

endinterface

// File: rtl/next_ch_find.sv
// Priority search for the lowest set mask bit strictly above ch, or the lowest set bit overall
// when from_start is high.
module next_ch_find #(
  parameter int N_CH  = 10,
  parameter int SEL_W = 4
) (
  input  logic [N_CH-1:0]  mask_i,
  input  logic [SEL_W-1:0] ch_i,
  input  logic             from_start_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  // Scanning downwards lets the lowest qualifying bit win.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (from_start_i || (SEL_W'(i) > ch_i))) begin
        found_o = 1'b1;
        idx_o   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sampler.sv
// Walks every unmasked mux channel, dwells SETTLE_CYC cycles on each, samples y_in on the last
// dwell cycle and hands the assembled snapshot downstream on a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for start; en=0, sel=0
//   SCAN  | dwelling on channel ch_q; en=1, sel=ch_q
//   DONE  | snapshot presented on data with valid=1 until ready
module mux_scan_sampler
  import mux_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_scan_sampler_if.master  bus
);

  localparam int CNT_W = dwell_cnt_w(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  data_q, data_d;

  logic             first_found;
  logic [SEL_W-1:0] first_idx;
  logic             next_found;
  logic [SEL_W-1:0] next_idx;

  logic [SEL_W-1:0] sel_w;
  logic             en_w;
  logic             valid_w;
  logic             busy_w;

  // First channel is searched on the live mask so SCAN can begin right after the start edge.
  next_ch_find #(.N_CH(N_CH), .SEL_W(SEL_W)) u_first_find (
    .mask_i       (bus.mask),
    .ch_i         ('0),
    .from_start_i (1'b1),
    .found_o      (first_found),
    .idx_o        (first_idx)
  );

  next_ch_find #(.N_CH(N_CH), .SEL_W(SEL_W)) u_next_find (
    .mask_i       (mask_q),
    .ch_i         (ch_q),
    .from_start_i (1'b0),
    .found_o      (next_found),
    .idx_o        (next_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    sel_w    = '0;
    en_w     = 1'b0;
    valid_w  = 1'b0;
    busy_w   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d   = bus.mask;
          shadow_d = '0;
          data_d   = '0;
          cnt_d    = '0;
          if (first_found) begin
            ch_d    = first_idx;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SCAN: begin
        en_w   = 1'b1;
        sel_w  = ch_q;
        busy_w = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < N_CH; i++) begin
            if (ch_q == SEL_W'(i)) shadow_d[i] = bus.y_in;
          end
          // en stays high across the channel change; only sel moves.
          if (next_found) begin
            ch_d = next_idx;
          end else begin
            data_d  = shadow_d;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        valid_w = 1'b1;
        busy_w  = 1'b1;
        if (bus.ready) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.sel   = sel_w;
  assign bus.en    = en_w;
  assign bus.valid = valid_w;
  assign bus.busy  = busy_w;
  assign bus.data  = data_q;

endmodule
